// File: rtl/parking_spot_allocator_pkg.sv
// Shared sizing, state encoding and helpers for the parking spot allocator.
package parking_spot_allocator_pkg;

    localparam int N_SPOTS = 8;
    localparam int IDX_W   = 3;
    localparam int TIMEOUT = 16;
    localparam int TMR_W   = $clog2(TIMEOUT);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_RESERVED = 1'b1
    } state_e;

    function automatic logic [N_SPOTS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_SPOTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/parking_spot_allocator_lowest_free_finder.sv
// Combinational priority encoder: index of the lowest set bit of free_mask.
module parking_spot_allocator_lowest_free_finder
    import parking_spot_allocator_pkg::*;
(
    input  logic [N_SPOTS-1:0] free_mask,
    output logic [IDX_W-1:0]   idx,
    output logic               any_free
);

    always_comb begin
        idx      = '0;
        any_free = |free_mask;
        for (int i = N_SPOTS - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/parking_spot_allocator.sv
// Occupancy bitmap owner: grants lowest free spot, holds one reservation with
// timeout, and frees spots on exit events.
//
//   state       | meaning
//   ST_IDLE     | no reservation in flight; entry_req may be granted
//   ST_RESERVED | spot resv_idx held for a car, waiting for park_confirm or timeout
module parking_spot_allocator
    import parking_spot_allocator_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               entry_req,
    output logic               entry_ack,
    output logic [IDX_W-1:0]   spot_idx,
    input  logic               park_confirm,
    input  logic               exit_valid,
    input  logic [IDX_W-1:0]   exit_idx,
    output logic [N_SPOTS-1:0] occupancy,
    output logic               full,
    output logic               timeout_pulse,
    output logic               err_pulse
);

    state_e             state_q, state_d;
    logic [N_SPOTS-1:0] parked_q, parked_d;
    logic [IDX_W-1:0]   resv_idx_q, resv_idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [N_SPOTS-1:0] occupancy_q, occupancy_d;
    logic               full_q, full_d;
    logic               entry_ack_q, entry_ack_d;
    logic               timeout_q, timeout_d;
    logic               err_q, err_d;

    logic [IDX_W-1:0]   free_idx;
    logic               free_any;
    logic               exit_in_range;

    // Allocation looks at the registered bitmap, so a spot freed this cycle waits a cycle.
    parking_spot_allocator_lowest_free_finder u_finder (
        .free_mask (~occupancy_q),
        .idx       (free_idx),
        .any_free  (free_any)
    );

    assign exit_in_range = 32'(exit_idx) < N_SPOTS;

    always_comb begin
        state_d     = state_q;
        parked_d    = parked_q;
        resv_idx_d  = resv_idx_q;
        timer_d     = timer_q;
        entry_ack_d = 1'b0;
        timeout_d   = 1'b0;
        err_d       = 1'b0;

        // The reserved spot is not in parked_q, so exiting it is flagged too.
        if (exit_valid) begin
            if (exit_in_range && parked_q[exit_idx]) begin
                parked_d[exit_idx] = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (entry_req && !full_q && free_any) begin
                    state_d     = ST_RESERVED;
                    resv_idx_d  = free_idx;
                    entry_ack_d = 1'b1;
                    timer_d     = TMR_W'(TIMEOUT - 1);
                end
            end
            ST_RESERVED: begin
                if (park_confirm) begin
                    parked_d[resv_idx_q] = 1'b1;
                    state_d              = ST_IDLE;
                end else if (timer_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        occupancy_d = parked_d | ((state_d == ST_RESERVED) ? onehot(resv_idx_d) : '0);
        full_d      = &occupancy_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            parked_q    <= '0;
            resv_idx_q  <= '0;
            timer_q     <= '0;
            occupancy_q <= '0;
            full_q      <= 1'b0;
            entry_ack_q <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            parked_q    <= parked_d;
            resv_idx_q  <= resv_idx_d;
            timer_q     <= timer_d;
            occupancy_q <= occupancy_d;
            full_q      <= full_d;
            entry_ack_q <= entry_ack_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
        end
    end

    assign entry_ack     = entry_ack_q;
    assign spot_idx      = resv_idx_q;
    assign occupancy     = occupancy_q;
    assign full          = full_q;
    assign timeout_pulse = timeout_q;
    assign err_pulse     = err_q;

endmodule
